// File: rtl/codif_scheduler_if.sv
// Bundle between the encoder-sharing scheduler, its requesters, the encoder and the result consumer.
// Latency: none, wires only.
// Backpressure: carries req_valid/req_grant and res_valid/res_ack; flow control lives in the scheduler.
// Ports: req_valid/req_data/req_grant (requesters), enc_* (encoder), res_* (consumer), busy (status).
interface codif_scheduler_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_data;
    logic [N-1:0]   req_grant;
    logic           enc_a;
    logic           enc_b;
    logic           enc_c;
    logic           enc_d;
    logic           enc_ready;
    logic           enc_reset;
    logic [3:0]     enc_s;
    logic           res_valid;
    logic [3:0]     res_data;
    logic [IDW-1:0] res_id;
    logic           res_ack;
    logic           busy;

    // Scheduler side
    modport master (
        input  req_valid, req_data, enc_s, res_ack,
        output req_grant, enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset,
               res_valid, res_data, res_id, busy
    );

    // Requesters, encoder and consumer side
    modport slave (
        output req_valid, req_data, enc_s, res_ack,
        input  req_grant, enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset,
               res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/codif_scheduler.sv
// Round-robin arbiter + sequencer sharing one encoder among N requesters (clear pulse, load, capture).
// Latency: grant cycle 0, enc_reset cycle 1, enc_ready cycles 2..1+SETTLE, res_valid from cycle 2+SETTLE.
// Backpressure: res_valid holds until res_ack; no new grant is issued until the result is accepted.
// Ports: clk, reset (sync, active-low), bus (codif_scheduler_if.master).
module codif_scheduler #(
    parameter int N      = 4,
    parameter int IDW    = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    codif_scheduler_if.master  bus
);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RESULT} state_t;

    // The LOAD counter also covers the cycle that turns enc_reset off, so it counts 0..SETTLE.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] lat_id;
    logic [3:0]     lat_data;
    logic [CW-1:0]  cnt;

    logic           found;
    logic [IDW-1:0] sel;
    logic [N-1:0]   sel_onehot;
    logic [3:0]     sel_data;

    // Round-robin pick: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        found      = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && bus.req_valid[i] && (IDW'(i) >= ptr)) begin
                found         = 1'b1;
                sel           = IDW'(i);
                sel_onehot[i] = 1'b1;
                sel_data      = bus.req_data[4*i +: 4];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && bus.req_valid[i] && (IDW'(i) < ptr)) begin
                found         = 1'b1;
                sel           = IDW'(i);
                sel_onehot[i] = 1'b1;
                sel_data      = bus.req_data[4*i +: 4];
            end
        end
    end

    // Outputs are registered with the values belonging to the cycle after each edge,
    // so the encoder sees its clear pulse one cycle after the grant pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            lat_id        <= '0;
            lat_data      <= '0;
            cnt           <= '0;
            bus.req_grant <= '0;
            bus.enc_a     <= 1'b0;
            bus.enc_b     <= 1'b0;
            bus.enc_c     <= 1'b0;
            bus.enc_d     <= 1'b0;
            bus.enc_ready <= 1'b0;
            bus.enc_reset <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.enc_reset <= 1'b0;
                    bus.enc_ready <= 1'b0;
                    bus.req_grant <= '0;
                    if (found) begin
                        bus.req_grant <= sel_onehot;
                        lat_data      <= sel_data;
                        lat_id        <= sel;
                        bus.busy      <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    bus.req_grant <= '0;
                    bus.enc_reset <= 1'b1;
                    bus.enc_ready <= 1'b0;
                    {bus.enc_a, bus.enc_b, bus.enc_c, bus.enc_d} <= lat_data;
                    cnt           <= '0;
                    state         <= LOAD;
                end
                LOAD: begin
                    bus.enc_reset <= 1'b0;
                    bus.enc_ready <= 1'b1;
                    // enc_s is only looked at on the edge that ends the last ready-high cycle.
                    if (cnt == LAST) begin
                        bus.res_data  <= bus.enc_s;
                        bus.res_id    <= lat_id;
                        bus.res_valid <= 1'b1;
                        state         <= RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ack) begin
                        bus.res_valid <= 1'b0;
                        bus.enc_ready <= 1'b0;
                        bus.busy      <= 1'b0;
                        ptr           <= (lat_id == IDW'(N - 1)) ? '0 : lat_id + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codif_scheduler.sv
// Directed bench for codif_scheduler: three instances (N=4/SETTLE=1, N=3/SETTLE=1, N=4/SETTLE=3).
// The encoder stand-in produces a Gray code of {A,B,C,D} while ready and not in reset.
// Expected values are hand-computed constants.
module tb_codif_scheduler;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    codif_scheduler_if #(.N(4), .IDW(2)) b0();
    codif_scheduler_if #(.N(3), .IDW(2)) b1();
    codif_scheduler_if #(.N(4), .IDW(2)) b2();

    codif_scheduler #(.N(4), .IDW(2), .SETTLE(1)) u0 (.clk(clk), .reset(reset), .bus(b0.master));
    codif_scheduler #(.N(3), .IDW(2), .SETTLE(1)) u1 (.clk(clk), .reset(reset), .bus(b1.master));
    codif_scheduler #(.N(4), .IDW(2), .SETTLE(3)) u2 (.clk(clk), .reset(reset), .bus(b2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder stand-ins for u0 and u1; u2's enc_s is driven directly by the stimulus.
    always_comb begin
        logic [3:0] x0;
        x0 = {b0.enc_a, b0.enc_b, b0.enc_c, b0.enc_d};
        b0.enc_s = (b0.enc_ready && !b0.enc_reset) ? (x0 ^ (x0 >> 1)) : 4'h0;
    end
    always_comb begin
        logic [3:0] x1;
        x1 = {b1.enc_a, b1.enc_b, b1.enc_c, b1.enc_d};
        b1.enc_s = (b1.enc_ready && !b1.enc_reset) ? (x1 ^ (x1 >> 1)) : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0]  gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0]  t2_grant [6]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0]  t2_id    [6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0]  t2_data  [6]  = '{4'h6, 4'hD, 4'h3, 4'hB, 4'h6, 4'hD};

    initial begin
        int t;
        int prev;
        int bad;
        logic [3:0] v4;

        cyc = 0; n_checks = 0; n_fail = 0;
        reset = 1'b0;
        b0.req_valid = '0; b0.req_data = '0; b0.res_ack = 1'b0;
        b1.req_valid = '0; b1.req_data = '0; b1.res_ack = 1'b0;
        b2.req_valid = '0; b2.req_data = '0; b2.res_ack = 1'b0; b2.enc_s = 4'h0;
        tick();
        tick();

        // Reset state
        check("rst_grant",     b0.req_grant, 4'b0000);
        check("rst_enc_reset", b0.enc_reset, 1'b1);
        check("rst_enc_ready", b0.enc_ready, 1'b0);
        check("rst_enc_abcd",  {b0.enc_a, b0.enc_b, b0.enc_c, b0.enc_d}, 4'h0);
        check("rst_res_valid", b0.res_valid, 1'b0);
        check("rst_res",       {b0.res_data, b0.res_id}, 6'h0);
        check("rst_busy",      b0.busy, 1'b0);
        check("rst_busy_u2",   b2.busy, 1'b0);
        reset = 1'b1;
        tick();

        // 1: single request, cycle by cycle
        b0.req_valid = 4'b0001;
        b0.req_data  = 16'h0005;
        b0.res_ack   = 1'b1;
        tick();
        check("t1_c0_grant", b0.req_grant, 4'b0001);
        check("t1_c0_busy",  b0.busy, 1'b1);
        b0.req_valid = 4'b0000;
        tick();
        check("t1_c1_enc_reset", b0.enc_reset, 1'b1);
        check("t1_c1_enc_ready", b0.enc_ready, 1'b0);
        check("t1_c1_grant",     b0.req_grant, 4'b0000);
        tick();
        check("t1_c2_enc_ready", b0.enc_ready, 1'b1);
        check("t1_c2_enc_reset", b0.enc_reset, 1'b0);
        check("t1_c2_abcd",      {b0.enc_a, b0.enc_b, b0.enc_c, b0.enc_d}, 4'b0101);
        check("t1_c2_res_valid", b0.res_valid, 1'b0);
        tick();
        check("t1_c3_res_valid", b0.res_valid, 1'b1);
        check("t1_c3_res_id",    b0.res_id, 2'd0);
        check("t1_c3_res_data",  b0.res_data, 4'h7);
        tick();
        check("t1_c4_res_valid", b0.res_valid, 1'b0);
        check("t1_c4_busy",      b0.busy, 1'b0);

        // 2: fairness with all four requesting continuously
        pulse_reset();
        b0.req_valid = 4'b1111;
        b0.req_data  = {4'hD, 4'h2, 4'h9, 4'h4};
        b0.res_ack   = 1'b1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            t = 0;
            while (b0.req_grant == 4'b0000 && t < 20) begin tick(); t++; end
            check($sformatf("t2_grant%0d", k), b0.req_grant, t2_grant[k]);
            if (k > 0) check($sformatf("t2_spacing%0d", k), cyc - prev, 5);
            prev = cyc;
            t = 0;
            while (!b0.res_valid && t < 20) begin tick(); t++; end
            check($sformatf("t2_id%0d", k),   b0.res_id,   t2_id[k]);
            check($sformatf("t2_data%0d", k), b0.res_data, t2_data[k]);
            if (k == 5) b0.req_valid = 4'b0000;
        end
        tick();

        // 3: backpressure with requesters 1 and 2 pending
        pulse_reset();
        b0.req_valid = 4'b0110;
        b0.req_data  = {4'h0, 4'h3, 4'hA, 4'h0};
        b0.res_ack   = 1'b0;
        t = 0;
        while (b0.req_grant == 4'b0000 && t < 20) begin tick(); t++; end
        check("t3_grant1", b0.req_grant, 4'b0010);
        b0.req_valid = 4'b0100;
        t = 0;
        while (!b0.res_valid && t < 20) begin tick(); t++; end
        check("t3_res", {b0.res_valid, b0.res_data, b0.res_id}, {1'b1, 4'hF, 2'd1});
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("t3_hold%0d", k),
                  {b0.res_valid, b0.res_data, b0.res_id, b0.req_grant},
                  {1'b1, 4'hF, 2'd1, 4'b0000});
        end
        b0.res_ack = 1'b1;
        t = 0;
        while (b0.req_grant == 4'b0000 && t < 20) begin tick(); t++; end
        check("t3_grant2", b0.req_grant, 4'b0100);
        b0.req_valid = 4'b0000;
        t = 0;
        while (!b0.res_valid && t < 20) begin tick(); t++; end
        check("t3_res2", {b0.res_data, b0.res_id}, {4'h2, 2'd2});
        tick();

        // 4: reset in the middle of LOAD; pointer had moved to 3
        b0.req_valid = 4'b1000;
        b0.req_data  = {4'h7, 4'h0, 4'h0, 4'hC};
        t = 0;
        while (b0.req_grant == 4'b0000 && t < 20) begin tick(); t++; end
        check("t4_grant3", b0.req_grant, 4'b1000);
        b0.req_valid = 4'b0000;
        tick();
        tick();
        check("t4_c2_enc_ready", b0.enc_ready, 1'b1);
        reset = 1'b0;
        tick();
        check("t4_enc_reset", b0.enc_reset, 1'b1);
        check("t4_enc_ready", b0.enc_ready, 1'b0);
        check("t4_busy",      b0.busy, 1'b0);
        check("t4_res_valid", b0.res_valid, 1'b0);
        reset = 1'b1;
        b0.req_valid = 4'b1001;
        bad = 0;
        t = 0;
        while (b0.req_grant == 4'b0000 && t < 20) begin
            if (b0.res_valid) bad++;
            tick();
            t++;
        end
        check("t4_no_result", bad, 0);
        check("t4_grant0",    b0.req_grant, 4'b0001);
        b0.req_valid = 4'b0000;
        t = 0;
        while (!b0.res_valid && t < 20) begin tick(); t++; end
        check("t4_res", {b0.res_data, b0.res_id}, {4'hA, 2'd0});
        tick();

        // 5: N=3, requester 2 sweeps all 16 values
        b1.res_ack = 1'b1;
        for (int v = 0; v < 16; v++) begin
            v4 = 4'(v);
            b1.req_data  = {v4, ~v4, v4 ^ 4'h5};
            b1.req_valid = 3'b100;
            t = 0;
            while (b1.req_grant == 3'b000 && t < 20) begin tick(); t++; end
            check($sformatf("t5_grant%0d", v), b1.req_grant, 3'b100);
            b1.req_valid = 3'b000;
            t = 0;
            while (!b1.res_valid && t < 20) begin tick(); t++; end
            check($sformatf("t5_data%0d", v), b1.res_data, gray_tab[v]);
            check($sformatf("t5_id%0d", v),   b1.res_id, 2'd2);
            tick();
        end
        // After requester N-1 the pointer wraps to 0
        b1.req_valid = 3'b011;
        t = 0;
        while (b1.req_grant == 3'b000 && t < 20) begin tick(); t++; end
        check("t5_wrap_grant", b1.req_grant, 3'b001);
        b1.req_valid = 3'b000;
        t = 0;
        while (!b1.res_valid && t < 20) begin tick(); t++; end
        tick();

        // 6: SETTLE=3, only the last LOAD cycle's enc_s is captured
        b2.res_ack   = 1'b1;
        b2.req_data  = 16'h0050;
        b2.req_valid = 4'b0010;
        t = 0;
        while (b2.req_grant == 4'b0000 && t < 20) begin tick(); t++; end
        check("t6_grant", b2.req_grant, 4'b0010);
        prev = cyc;
        b2.req_valid = 4'b0000;
        tick();
        check("t6_c1_enc_reset", b2.enc_reset, 1'b1);
        tick();
        check("t6_c2_enc_ready", b2.enc_ready, 1'b1);
        b2.enc_s = 4'hF;
        tick();
        b2.enc_s = 4'h9;
        tick();
        check("t6_c4_res_valid", b2.res_valid, 1'b0);
        b2.enc_s = 4'h6;
        tick();
        check("t6_c5_res_valid", b2.res_valid, 1'b1);
        check("t6_res_data",     b2.res_data, 4'h6);
        check("t6_res_id",       b2.res_id, 2'd1);
        check("t6_latency",      cyc - prev, 5);
        tick();
        check("t6_idle", b2.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
